// File: rtl/light_pkg.sv
// Shared definitions for the junction phase scheduler.
//   phase_t      : lamp phase encoding (value 7 is unused and treated as illegal)
//   PHASE_W      : width of the phase encoding
//   T_*_DEF      : default phase durations in 1 Hz ticks
//   CW_DEF       : default width of the remaining-time counter
package light_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    S_JG  = 3'd0,
    S_JY  = 3'd1,
    S_AR1 = 3'd2,
    S_CG  = 3'd3,
    S_CY  = 3'd4,
    S_AR2 = 3'd5,
    S_PW  = 3'd6
  } phase_t;

  localparam int T_JG_DEF     = 30;
  localparam int T_JY_DEF     = 3;
  localparam int T_AR_DEF     = 1;
  localparam int T_CG_DEF     = 20;
  localparam int T_CY_DEF     = 3;
  localparam int T_WALK_DEF   = 10;
  localparam int T_JG_MIN_DEF = 5;
  localparam int CW_DEF       = 8;

endpackage

// File: rtl/phase_timer.sv
// Down counter holding the ticks left in the current phase, minus one.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-low reset, loads RST_VAL
//   load     : load load_val (takes priority over en)
//   load_val : value loaded on load
//   en       : decrement by one (tick strobe)
//   cnt      : current count
//   zero     : cnt is zero (terminal count)
module phase_timer #(
  parameter int             CW      = 8,
  parameter logic [CW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/light_phase_sched.sv
// Phase scheduler for a two-road junction (J main, C cross) with a
// pedestrian walk phase that replaces the cross-road green when requested.
// Optional build macro: PED_SHORTEN_EN -- a pending request trims the
// main-road green down to T_JG_MIN ticks.
//
// state | meaning
// S_JG  | main green, cross red
// S_JY  | main yellow, cross red
// S_AR1 | all red before cross road / walk
// S_CG  | cross green, main red
// S_CY  | cross yellow, main red
// S_AR2 | all red before main road
// S_PW  | pedestrian walk, both roads red
//
// Ports:
//   clk    : system clock
//   rst    : synchronous active-low reset
//   tick   : one-clk 1 Hz enable strobe
//   N      : pedestrian push-button request
//   Jg/Jy/Jr, Cg/Cy/Cr : lamp drives per road
//   P      : pedestrian walk lamp
//   pend   : request latched, not yet served
//   phase  : current state encoding
//   remain : ticks left in current phase minus one
module light_phase_sched
  import light_pkg::*;
#(
  parameter int T_JG     = T_JG_DEF,
  parameter int T_JY     = T_JY_DEF,
  parameter int T_AR     = T_AR_DEF,
  parameter int T_CG     = T_CG_DEF,
  parameter int T_CY     = T_CY_DEF,
  parameter int T_WALK   = T_WALK_DEF,
  parameter int T_JG_MIN = T_JG_MIN_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               N,
  output logic               Jg,
  output logic               Jy,
  output logic               Jr,
  output logic               Cg,
  output logic               Cy,
  output logic               Cr,
  output logic               P,
  output logic               pend,
  output logic [PHASE_W-1:0] phase,
  output logic [CW-1:0]      remain
);

  // A duration of 0 would underflow the counter; it is run as 1 tick.
  function automatic logic [CW-1:0] dur_m1(input int t);
    return (t <= 1) ? '0 : CW'(t - 1);
  endfunction

  localparam logic [CW-1:0] L_JG     = dur_m1(T_JG);
  localparam logic [CW-1:0] L_JY     = dur_m1(T_JY);
  localparam logic [CW-1:0] L_AR     = dur_m1(T_AR);
  localparam logic [CW-1:0] L_CG     = dur_m1(T_CG);
  localparam logic [CW-1:0] L_CY     = dur_m1(T_CY);
  localparam logic [CW-1:0] L_WALK   = dur_m1(T_WALK);
  localparam logic [CW-1:0] L_JG_MIN = dur_m1(T_JG_MIN);

`ifdef PED_SHORTEN_EN
  localparam bit SHORTEN = 1'b1;
`else
  localparam bit SHORTEN = 1'b0;
`endif

  phase_t          state, state_n;
  logic            adv;
  logic            tmr_load;
  logic [CW-1:0]   tmr_val;
  logic            tmr_zero;
  logic            enter_pw;

  assign adv = tick && tmr_zero;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_JG;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = L_JG;
    enter_pw = 1'b0;

    case (state)
      S_JG:    if (adv) state_n = S_JY;
      S_JY:    if (adv) state_n = S_AR1;
      S_AR1:   if (adv) state_n = pend ? S_PW : S_CG;
      S_CG:    if (adv) state_n = S_CY;
      S_CY:    if (adv) state_n = S_AR2;
      S_AR2:   if (adv) state_n = S_JG;
      S_PW:    if (adv) state_n = S_AR2;
      default: state_n = S_AR2;   // illegal code recovers without waiting for a tick
    endcase

    if (state_n != state) begin
      tmr_load = 1'b1;
      enter_pw = (state_n == S_PW);
      case (state_n)
        S_JG:    tmr_val = L_JG;
        S_JY:    tmr_val = L_JY;
        S_AR1:   tmr_val = L_AR;
        S_CG:    tmr_val = L_CG;
        S_CY:    tmr_val = L_CY;
        S_AR2:   tmr_val = L_AR;
        S_PW:    tmr_val = L_WALK;
        default: tmr_val = L_AR;
      endcase
    end else if (SHORTEN && state == S_JG && pend && tick && remain > L_JG_MIN) begin
      // Trim rather than decrement so the walk is reached sooner.
      tmr_load = 1'b1;
      tmr_val  = L_JG_MIN;
    end
  end

  phase_timer #(
    .CW      (CW),
    .RST_VAL (L_JG)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tick),
    .cnt      (remain),
    .zero     (tmr_zero)
  );

  // A new press on the entry edge wins, so it is served on the next round.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend <= 1'b0;
    end else if (N) begin
      pend <= 1'b1;
    end else if (enter_pw) begin
      pend <= 1'b0;
    end
  end

  assign Jg    = (state == S_JG);
  assign Jy    = (state == S_JY);
  assign Jr    = !(Jg || Jy);
  assign Cg    = (state == S_CG);
  assign Cy    = (state == S_CY);
  assign Cr    = !(Cg || Cy);
  assign P     = (state == S_PW);
  assign phase = state;

endmodule

// File: tb/tb_light_phase_sched.sv
module tb_light_phase_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       N = 1'b0;
  logic       Jg, Jy, Jr, Cg, Cy, Cr, P, pend;
  logic [2:0] phase;
  logic [7:0] remain;

  light_phase_sched #(
    .T_JG(5), .T_JY(2), .T_AR(1), .T_CG(4), .T_CY(2), .T_WALK(3),
    .T_JG_MIN(2), .CW(8)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .N(N),
    .Jg(Jg), .Jy(Jy), .Jr(Jr), .Cg(Cg), .Cy(Cy), .Cr(Cr), .P(P),
    .pend(pend), .phase(phase), .remain(remain)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase number plus ticks elapsed inside it.
  int dur [7] = '{5, 2, 1, 4, 2, 1, 3};
  localparam int TMIN = 2;
  int m_phase = 0;
  int m_el    = 0;
  bit m_pend  = 0;
  int tcnt    = 0;
  int pw_entries = 0;

  function automatic int succ(input int ph, input bit pr);
    case (ph)
      0: return 1;
      1: return 2;
      2: return pr ? 6 : 3;
      3: return 4;
      4: return 5;
      5: return 0;
      default: return 5;
    endcase
  endfunction

  function automatic int m_remain();
    return dur[m_phase] - 1 - m_el;
  endfunction

  task automatic model_step(input bit r, input bit tk, input bit n);
    bit into_pw;
    into_pw = 0;
    if (!r) begin
      m_phase = 0; m_el = 0; m_pend = 0;
    end else begin
      if (tk) begin
        if (m_el == dur[m_phase] - 1) begin
          m_phase = succ(m_phase, m_pend);
          m_el = 0;
          if (m_phase == 6) begin
            into_pw = 1;
            pw_entries++;
          end
        end else begin
`ifdef PED_SHORTEN_EN
          if (m_phase == 0 && m_pend && m_remain() > TMIN - 1)
            m_el = dur[0] - TMIN;
          else
            m_el++;
`else
          m_el++;
`endif
        end
      end
      if (n) m_pend = 1;
      else if (into_pw) m_pend = 0;
    end
  endtask

  task automatic check_all();
    check("phase",  int'(phase),  m_phase);
    check("remain", int'(remain), m_remain());
    check("pend",   int'(pend),   int'(m_pend));
    check("Jg", int'(Jg), int'(m_phase == 0));
    check("Jy", int'(Jy), int'(m_phase == 1));
    check("Jr", int'(Jr), int'(m_phase >= 2));
    check("Cg", int'(Cg), int'(m_phase == 3));
    check("Cy", int'(Cy), int'(m_phase == 4));
    check("Cr", int'(Cr), int'(m_phase != 3 && m_phase != 4));
    check("P",  int'(P),  int'(m_phase == 6));
    check("inv_two_greens", int'(Jg & Cg), 0);
    check("inv_green_walk", int'(P & (Jg | Cg)), 0);
    check("inv_onehot_J", int'(Jg) + int'(Jy) + int'(Jr), 1);
    check("inv_onehot_C", int'(Cg) + int'(Cy) + int'(Cr), 1);
  endtask

  // One clock: drive at negedge, model at posedge, sample #1 later.
  task automatic cyc(input bit r, input bit n);
    bit tk;
    @(negedge clk);
    tk = (tcnt == 3);
    tcnt = (tcnt + 1) % 4;
    rst = r; tick = tk; N = n;
    @(posedge clk);
    model_step(r, tk, n);
    #1;
    check_all();
  endtask

  initial begin
    int budget;
    int jg_ticks;

    // 1: reset, then two full rounds without requests
    repeat (3) cyc(0, 0);
    check("rst_remain", int'(remain), 4);
    check("rst_Jg", int'(Jg), 1);
    repeat (130) cyc(1, 0);

    // 2: single-clock press during main green tick 1
    budget = 200;
    while (!(m_phase == 0 && m_el == 1) && budget > 0) begin cyc(1, 0); budget--; end
    check("wait_jg_t1", int'(budget > 0), 1);
    cyc(1, 1);
    check("pend_set", int'(pend), 1);
    budget = 200;
    while (m_phase != 6 && budget > 0) begin cyc(1, 0); budget--; end
    check("reach_pw", int'(P), 1);
    check("pw_pend_clr", int'(pend), 0);
    repeat (80) cyc(1, 0);

    // 3: press again on the edge that enters walk
    cyc(1, 1);
    budget = 300;
    while (pw_entries < 2 && budget > 0) begin
      cyc(1, (tcnt == 3) && m_phase == 2 && m_pend);
      budget--;
    end
    check("pw_second", pw_entries, 2);
    check("pend_kept", int'(pend), 1);
    budget = 300;
    while (pw_entries < 3 && budget > 0) begin cyc(1, 0); budget--; end
    check("pw_third", pw_entries, 3);

    // 4: reset mid cross-green with remain=2
    budget = 300;
    while (!(m_phase == 3 && m_remain() == 2) && budget > 0) begin cyc(1, 0); budget--; end
    check("wait_cg_r2", int'(remain), 2);
    cyc(0, 1);
    check("mid_rst_phase", int'(phase), 0);
    check("mid_rst_remain", int'(remain), 4);
    check("mid_rst_Jg", int'(Jg), 1);
    check("mid_rst_pend", int'(pend), 0);

    // 6: press at main green remain=4, measure main green length
    repeat (4) cyc(1, 0);   // realign so tick edges are regular
    budget = 300;
    while (!(m_phase == 5 && (tcnt == 3)) && budget > 0) begin cyc(1, 0); budget--; end
    check("wait_ar2", m_phase, 5);
    cyc(1, 0);              // enter S_JG, remain=4
    cyc(1, 1);
    jg_ticks = 0;
    budget = 200;
    while (m_phase == 0 && budget > 0) begin
      if (tcnt == 3) jg_ticks++;
      cyc(1, 0);
      budget--;
    end
`ifdef PED_SHORTEN_EN
    check("jg_len_short", jg_ticks, 3);
`else
    check("jg_len_full", jg_ticks, 5);
`endif
    check("jg_exit", int'(phase), 1);

    // random soak: sparse presses and occasional resets
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 24) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
